ddr2_ring_ctrl: RTL and testbench

Parametrised successor to the DDR2 FIFO controller: it uses a region of DDR2 as a large circular FIFO between an upstream write FIFO and a downstream read FIFO. It drains write-FIFO words into MIG write bursts and issues read bursts back out of the ring. It sits between the user FIFOs and the MIG application interface (app_af_*/app_wdf_*). Against the previous generation it adds:
- generic burst length and ring depth;
- ring full/empty/level tracking with address wrap;
- round-robin read/write arbitration;
- read-credit flow control against the downstream FIFO;
- a sticky overflow flag.

---
 rtl/ddr2_ring_ctrl_if.sv | 45 ++++
 rtl/ddr2_ring_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_ddr2_ring_ctrl.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr2_ring_ctrl_if.sv
// ddr2_ring_ctrl_if
// Bundles every non-clock/non-reset signal of ddr2_ring_ctrl: upstream
// write-FIFO handshake, downstream read-FIFO credit, MIG app_af_*/app_wdf_*
// command and data ports, and ring status/error outputs.
//   master : the ring controller (drives wr_fifo_rd, app_*, ring_*, overflow_err)
//   slave  : the surrounding FIFOs / MIG model (drives everything else)
interface ddr2_ring_ctrl_if #(
   parameter int DATA_WIDTH  = 64,
   parameter int COUNT_WIDTH = 10,
   parameter int RING_LOG2   = 16
);
   logic                   phy_init_done;
   logic [COUNT_WIDTH-1:0] wr_fifo_count;
   logic [DATA_WIDTH-1:0]  wr_fifo_dout;
   logic                   wr_fifo_full;
   logic                   data_in_vd;
   logic [COUNT_WIDTH-1:0] rd_fifo_free;
   logic                   rd_data_valid;
   logic                   app_wdf_afull;
   logic                   app_af_afull;
   logic                   wr_fifo_rd;
   logic                   app_af_wren;
   logic [30:0]            app_af_addr;
   logic [2:0]             app_af_cmd;
   logic [DATA_WIDTH-1:0]  app_wdf_data;
   logic                   app_wdf_wren;
   logic [RING_LOG2:0]     ring_level;
   logic                   ring_full;
   logic                   ring_empty;
   logic                   overflow_err;

   modport master (
      input  phy_init_done, wr_fifo_count, wr_fifo_dout, wr_fifo_full, data_in_vd,
             rd_fifo_free, rd_data_valid, app_wdf_afull, app_af_afull,
      output wr_fifo_rd, app_af_wren, app_af_addr, app_af_cmd, app_wdf_data,
             app_wdf_wren, ring_level, ring_full, ring_empty, overflow_err
   );

   modport slave (
      output phy_init_done, wr_fifo_count, wr_fifo_dout, wr_fifo_full, data_in_vd,
             rd_fifo_free, rd_data_valid, app_wdf_afull, app_af_afull,
      input  wr_fifo_rd, app_af_wren, app_af_addr, app_af_cmd, app_wdf_data,
             app_wdf_wren, ring_level, ring_full, ring_empty, overflow_err
   );
endinterface

// File: rtl/ddr2_ring_ctrl.sv
// ddr2_ring_ctrl
// Uses a region of DDR2 as a circular FIFO of 2^RING_LOG2 bursts. Words are
// drained from the upstream write FIFO into MIG write bursts and read back
// out with MIG read bursts, with round-robin arbitration between the two and
// read-credit flow control against the downstream FIFO.
// Ports:
//   sys_clk : system clock (single domain)
//   reset   : asynchronous, active-high reset
//   bus     : ddr2_ring_ctrl_if.master (FIFO handshakes, MIG app_af_*/app_wdf_*,
//             ring_level/ring_full/ring_empty status, sticky overflow_err)
module ddr2_ring_ctrl #(
   parameter int          DATA_WIDTH  = 64,
   parameter int          BURST_LEN   = 8,
   parameter int          RING_LOG2   = 16,
   parameter logic [30:0] BASE_ADDR   = 31'd0,
   parameter int          COUNT_WIDTH = 10
) (
   input logic              sys_clk,
   input logic              reset,
   ddr2_ring_ctrl_if.master bus
);
   localparam int N     = BURST_LEN / 2;
   localparam int CNT_W = $clog2(N + 1);
   // Two spare bits so outstanding + N never wraps in the credit compare
   localparam int OUT_W = COUNT_WIDTH + 2;
   localparam logic [RING_LOG2:0] DEPTH = {1'b1, {RING_LOG2{1'b0}}};

   typedef enum logic [2:0] {IDLE, WR_DATA, WR_FLUSH, WR_CMD, RD_CMD} state_t;

   state_t                  state_r;
   logic [CNT_W-1:0]        rd_cnt_r;
   logic                    flush_r;
   logic                    last_grant_r;     // 1 = write won last, 0 = read
   logic [RING_LOG2-1:0]    wr_idx_r;
   logic [RING_LOG2-1:0]    rd_idx_r;
   logic [RING_LOG2:0]      ring_level_r;
   logic                    ring_full_r;
   logic                    ring_empty_r;
   logic [OUT_W-1:0]        rd_outstanding_r;
   logic                    wr_fifo_rd_r;
   logic                    rd_d1_r;
   logic                    app_wdf_wren_r;
   logic [DATA_WIDTH-1:0]   app_wdf_data_r;
   logic                    app_af_wren_r;
   logic [30:0]             app_af_addr_r;
   logic [2:0]              app_af_cmd_r;
   logic                    overflow_r;

   logic                    wr_elig_s;
   logic                    rd_elig_s;
   logic [OUT_W-1:0]        rd_need_s;
   logic [OUT_W-1:0]        rd_out_base_s;

   // Column address of ring slot idx, truncated to the 31-bit MIG address
   function automatic logic [30:0] ring_addr(input logic [RING_LOG2-1:0] idx);
      ring_addr = BASE_ADDR + 31'(idx) * 31'(BURST_LEN);
   endfunction

   // Eligibility of each requester and outstanding-read count after returns
   always_comb begin
      rd_need_s = rd_outstanding_r + OUT_W'(N);
      wr_elig_s = bus.phy_init_done & ~ring_full_r &
                  (bus.wr_fifo_count >= COUNT_WIDTH'(N));
      rd_elig_s = bus.phy_init_done & ~ring_empty_r &
                  (OUT_W'(bus.rd_fifo_free) >= rd_need_s);
      if (bus.rd_data_valid && (rd_outstanding_r != '0)) begin
         rd_out_base_s = rd_outstanding_r - OUT_W'(1);
      end else begin
         rd_out_base_s = rd_outstanding_r;
      end
   end

   // Main FSM: arbitration, write-FIFO draining, command issue, ring indices
   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         state_r          <= IDLE;
         rd_cnt_r         <= '0;
         flush_r          <= 1'b0;
         last_grant_r     <= 1'b0;
         wr_idx_r         <= '0;
         rd_idx_r         <= '0;
         ring_level_r     <= '0;
         ring_full_r      <= 1'b0;
         ring_empty_r     <= 1'b1;
         rd_outstanding_r <= '0;
         wr_fifo_rd_r     <= 1'b0;
         app_af_wren_r    <= 1'b0;
         app_af_addr_r    <= BASE_ADDR;
         app_af_cmd_r     <= 3'b000;
      end else begin
         wr_fifo_rd_r     <= 1'b0;
         app_af_wren_r    <= 1'b0;
         rd_outstanding_r <= rd_out_base_s;
         case (state_r)
            IDLE: begin
               // Write wins when it is alone or when read was granted last
               if (wr_elig_s && (!rd_elig_s || !last_grant_r)) begin
                  state_r      <= WR_DATA;
                  last_grant_r <= 1'b1;
                  rd_cnt_r     <= '0;
               end else if (rd_elig_s) begin
                  state_r      <= RD_CMD;
                  last_grant_r <= 1'b0;
               end else begin
                  state_r      <= IDLE;
               end
            end
            WR_DATA: begin
               if (!bus.app_wdf_afull) begin
                  wr_fifo_rd_r <= 1'b1;
                  rd_cnt_r     <= rd_cnt_r + CNT_W'(1);
                  if (rd_cnt_r == CNT_W'(N - 1)) begin
                     state_r <= WR_FLUSH;
                     flush_r <= 1'b0;
                  end
               end
            end
            WR_FLUSH: begin
               // Two cycles let the last FIFO word reach app_wdf_wren
               if (flush_r) begin
                  state_r <= WR_CMD;
               end else begin
                  flush_r <= 1'b1;
               end
            end
            WR_CMD: begin
               if (!bus.app_af_afull) begin
                  app_af_wren_r <= 1'b1;
                  app_af_addr_r <= ring_addr(wr_idx_r);
                  app_af_cmd_r  <= 3'b000;
                  wr_idx_r      <= wr_idx_r + 1'b1;
                  ring_level_r  <= ring_level_r + 1'b1;
                  ring_full_r   <= ((ring_level_r + 1'b1) == DEPTH);
                  ring_empty_r  <= 1'b0;
                  state_r       <= IDLE;
               end
            end
            RD_CMD: begin
               if (!bus.app_af_afull) begin
                  app_af_wren_r    <= 1'b1;
                  app_af_addr_r    <= ring_addr(rd_idx_r);
                  app_af_cmd_r     <= 3'b001;
                  rd_idx_r         <= rd_idx_r + 1'b1;
                  ring_level_r     <= ring_level_r - 1'b1;
                  ring_full_r      <= 1'b0;
                  ring_empty_r     <= (ring_level_r == {{RING_LOG2{1'b0}}, 1'b1});
                  rd_outstanding_r <= rd_out_base_s + OUT_W'(N);
                  state_r          <= IDLE;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   // Write-data pipeline: FIFO read at t, dout at t+1, MIG write data at t+2
   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         rd_d1_r        <= 1'b0;
         app_wdf_wren_r <= 1'b0;
         app_wdf_data_r <= '0;
      end else begin
         rd_d1_r        <= wr_fifo_rd_r;
         app_wdf_wren_r <= rd_d1_r;
         if (rd_d1_r) begin
            app_wdf_data_r <= bus.wr_fifo_dout;
         end
      end
   end

   // Sticky overflow flag, cleared only by reset
   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         overflow_r <= 1'b0;
      end else if (bus.data_in_vd && bus.wr_fifo_full) begin
         overflow_r <= 1'b1;
      end
   end

   assign bus.wr_fifo_rd   = wr_fifo_rd_r;
   assign bus.app_af_wren  = app_af_wren_r;
   assign bus.app_af_addr  = app_af_addr_r;
   assign bus.app_af_cmd   = app_af_cmd_r;
   assign bus.app_wdf_data = app_wdf_data_r;
   assign bus.app_wdf_wren = app_wdf_wren_r;
   assign bus.ring_level   = ring_level_r;
   assign bus.ring_full    = ring_full_r;
   assign bus.ring_empty   = ring_empty_r;
   assign bus.overflow_err = overflow_r;
endmodule

// File: tb/tb_ddr2_ring_ctrl.sv
// tb_ddr2_ring_ctrl
// Directed bench for ddr2_ring_ctrl with a 4-burst ring (RING_LOG2=2),
// BURST_LEN=8 (N=4 words per command) and BASE_ADDR=0x100. A small write-FIFO
// model supplies data; negedge monitors log FIFO reads, MIG data and commands.
module tb_ddr2_ring_ctrl;
   localparam int          DW   = 64;
   localparam int          CW   = 10;
   localparam int          RL   = 2;
   localparam logic [30:0] BASE = 31'h100;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ddr2_ring_ctrl_if #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW), .RING_LOG2(RL)) bus ();

   ddr2_ring_ctrl #(
      .DATA_WIDTH(DW), .BURST_LEN(8), .RING_LOG2(RL),
      .BASE_ADDR(BASE), .COUNT_WIDTH(CW)
   ) dut (
      .sys_clk(clk),
      .reset(rst),
      .bus(bus)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // write-FIFO model
   logic [63:0] wmem [0:255];
   int          wr_pushed = 0;
   int          wr_popped = 0;
   assign bus.wr_fifo_count = CW'(wr_pushed - wr_popped);

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus.wr_fifo_rd) begin
         bus.wr_fifo_dout <= wmem[wr_popped % 256];
         wr_popped        <= wr_popped + 1;
      end
   end

   // monitors
   int          rd_cnt  = 0;
   int          wdf_cnt = 0;
   int          cmd_cnt = 0;
   int          rd_cyc   [0:127];
   logic [63:0] wdf_data [0:127];
   int          wdf_cyc  [0:127];
   logic [30:0] cmd_addr [0:127];
   logic [2:0]  cmd_op   [0:127];
   int          cmd_cyc  [0:127];

   always @(negedge clk) begin
      if (bus.wr_fifo_rd && rd_cnt < 128) begin
         rd_cyc[rd_cnt] = cyc;
         rd_cnt = rd_cnt + 1;
      end
      if (bus.app_wdf_wren && wdf_cnt < 128) begin
         wdf_data[wdf_cnt] = bus.app_wdf_data;
         wdf_cyc[wdf_cnt]  = cyc;
         wdf_cnt = wdf_cnt + 1;
      end
      if (bus.app_af_wren && cmd_cnt < 128) begin
         cmd_addr[cmd_cnt] = bus.app_af_addr;
         cmd_op[cmd_cnt]   = bus.app_af_cmd;
         cmd_cyc[cmd_cnt]  = cyc;
         cmd_cnt = cmd_cnt + 1;
      end
   end

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int get_cnt(input int sel);
      case (sel)
         0:       return cmd_cnt;
         1:       return rd_cnt;
         default: return wdf_cnt;
      endcase
   endfunction

   // wait until a monitor count reaches target; an expired budget fails the check
   task automatic wait_cnt(input string tag, input int sel, input int target, input int budget);
      int k;
      k = 0;
      while (get_cnt(sel) < target && k < budget) begin
         @(negedge clk);
         #1;
         k++;
      end
      check_eq(tag, 64'(get_cnt(sel)), 64'(target));
   endtask

   task automatic push_words(input logic [63:0] first, input int n);
      for (int i = 0; i < n; i++) begin
         wmem[wr_pushed % 256] = first + 64'(i);
         wr_pushed++;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic ticks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   int base_c, base_r, base_w, drop_cyc;

   initial begin
      rst = 1'b1;
      bus.phy_init_done = 1'b0;
      bus.wr_fifo_full  = 1'b0;
      bus.data_in_vd    = 1'b0;
      bus.rd_fifo_free  = '0;
      bus.rd_data_valid = 1'b0;
      bus.app_wdf_afull = 1'b0;
      bus.app_af_afull  = 1'b0;

      // reset values
      ticks(2);
      check_eq("rst_wr_fifo_rd", 64'(bus.wr_fifo_rd), 64'd0);
      check_eq("rst_af_wren", 64'(bus.app_af_wren), 64'd0);
      check_eq("rst_af_addr", 64'(bus.app_af_addr), 64'(BASE));
      check_eq("rst_af_cmd", 64'(bus.app_af_cmd), 64'd0);
      check_eq("rst_wdf_wren", 64'(bus.app_wdf_wren), 64'd0);
      check_eq("rst_level", 64'(bus.ring_level), 64'd0);
      check_eq("rst_empty", 64'(bus.ring_empty), 64'd1);
      check_eq("rst_full", 64'(bus.ring_full), 64'd0);
      rst = 1'b0;
      bus.phy_init_done = 1'b1;

      // single write burst of 1..4
      push_words(64'h1, 4);
      wait_cnt("w1_cmd_wait", 0, 1, 60);
      check_eq("w1_rd_pulses", 64'(rd_cnt), 64'd4);
      check_eq("w1_wdf_words", 64'(wdf_cnt), 64'd4);
      for (int i = 0; i < 4; i++) check_eq("w1_wdf_data", wdf_data[i], 64'(i + 1));
      check_eq("w1_addr", 64'(cmd_addr[0]), 64'(BASE));
      check_eq("w1_cmd", 64'(cmd_op[0]), 64'd0);
      check_eq("w1_level", 64'(bus.ring_level), 64'd1);
      check_eq("w1_empty", 64'(bus.ring_empty), 64'd0);
      check_eq("w1_data_lag", 64'(wdf_cyc[0] - rd_cyc[0]), 64'd2);
      check_eq("w1_cmd_after_data", 64'(cmd_cyc[0] - wdf_cyc[3]), 64'd1);
      check_eq("w1_cmd_latency", 64'(cmd_cyc[0] - rd_cyc[0]), 64'd6);

      // read it back, then return the data
      bus.rd_fifo_free = 10'd64;
      wait_cnt("r1_cmd_wait", 0, 2, 30);
      bus.rd_fifo_free = 10'd0;
      check_eq("r1_cmd", 64'(cmd_op[1]), 64'd1);
      check_eq("r1_addr", 64'(cmd_addr[1]), 64'(BASE));
      check_eq("r1_level", 64'(bus.ring_level), 64'd0);
      check_eq("r1_empty", 64'(bus.ring_empty), 64'd1);
      check_eq("r1_outstanding", 64'(dut.rd_outstanding_r), 64'd4);
      bus.rd_data_valid = 1'b1;
      ticks(4);
      bus.rd_data_valid = 1'b0;
      check_eq("r1_outstanding_drained", 64'(dut.rd_outstanding_r), 64'd0);

      // fill the ring, then wrap after one read
      do_reset();
      base_c = cmd_cnt;
      base_r = rd_cnt;
      push_words(64'h10, 16);
      wait_cnt("fill_wait", 0, base_c + 4, 200);
      for (int i = 0; i < 4; i++) begin
         check_eq("fill_addr", 64'(cmd_addr[base_c + i]), 64'(BASE + 31'(8 * i)));
         check_eq("fill_cmd", 64'(cmd_op[base_c + i]), 64'd0);
      end
      check_eq("fill_full", 64'(bus.ring_full), 64'd1);
      check_eq("fill_level", 64'(bus.ring_level), 64'd4);
      push_words(64'h30, 4);
      ticks(30);
      check_eq("full_no_fifo_rd", 64'(rd_cnt), 64'(base_r + 16));
      check_eq("full_no_cmd", 64'(cmd_cnt), 64'(base_c + 4));
      bus.rd_fifo_free = 10'd4;
      wait_cnt("wrap_wait", 0, base_c + 6, 100);
      bus.rd_fifo_free = 10'd0;
      check_eq("wrap_rd_cmd", 64'(cmd_op[base_c + 4]), 64'd1);
      check_eq("wrap_rd_addr", 64'(cmd_addr[base_c + 4]), 64'(BASE));
      check_eq("wrap_wr_cmd", 64'(cmd_op[base_c + 5]), 64'd0);
      check_eq("wrap_wr_addr", 64'(cmd_addr[base_c + 5]), 64'(BASE));
      check_eq("wrap_full", 64'(bus.ring_full), 64'd1);

      // round robin: write first, then alternate
      do_reset();
      base_c = cmd_cnt;
      bus.rd_fifo_free = 10'd64;
      push_words(64'h50, 8);
      wait_cnt("rr_wait", 0, base_c + 4, 200);
      bus.rd_fifo_free = 10'd0;
      check_eq("rr_op0", 64'(cmd_op[base_c + 0]), 64'd0);
      check_eq("rr_op1", 64'(cmd_op[base_c + 1]), 64'd1);
      check_eq("rr_op2", 64'(cmd_op[base_c + 2]), 64'd0);
      check_eq("rr_op3", 64'(cmd_op[base_c + 3]), 64'd1);
      check_eq("rr_addr2", 64'(cmd_addr[base_c + 2]), 64'(BASE + 31'd8));
      check_eq("rr_addr3", 64'(cmd_addr[base_c + 3]), 64'(BASE + 31'd8));

      // back-pressure on both MIG FIFOs
      do_reset();
      base_c = cmd_cnt;
      base_r = rd_cnt;
      base_w = wdf_cnt;
      bus.app_af_afull = 1'b1;
      push_words(64'h21, 4);
      wait_cnt("bp_rd2_wait", 1, base_r + 2, 40);
      @(posedge clk);
      #1;
      bus.app_wdf_afull = 1'b1;
      ticks(5);
      bus.app_wdf_afull = 1'b0;
      wait_cnt("bp_wdf_wait", 2, base_w + 4, 60);
      ticks(5);
      check_eq("bp_rd_total", 64'(rd_cnt - base_r), 64'd4);
      check_eq("bp_rd_gap", 64'(rd_cyc[base_r + 3] - rd_cyc[base_r + 2]), 64'd6);
      check_eq("bp_rd_nogap", 64'(rd_cyc[base_r + 2] - rd_cyc[base_r + 1]), 64'd1);
      for (int i = 0; i < 4; i++) check_eq("bp_wdf_data", wdf_data[base_w + i], 64'h21 + 64'(i));
      check_eq("bp_cmd_held", 64'(cmd_cnt), 64'(base_c));
      drop_cyc = cyc;
      bus.app_af_afull = 1'b0;
      wait_cnt("bp_cmd_wait", 0, base_c + 1, 20);
      check_eq("bp_cmd_delay", 64'(cmd_cyc[base_c] - drop_cyc), 64'd1);
      check_eq("bp_cmd_addr", 64'(cmd_addr[base_c]), 64'(BASE));

      // sticky overflow
      check_eq("ovf_clear", 64'(bus.overflow_err), 64'd0);
      bus.data_in_vd = 1'b1;
      ticks(1);
      bus.data_in_vd = 1'b0;
      ticks(1);
      check_eq("ovf_vd_only", 64'(bus.overflow_err), 64'd0);
      bus.data_in_vd   = 1'b1;
      bus.wr_fifo_full = 1'b1;
      ticks(1);
      bus.data_in_vd   = 1'b0;
      bus.wr_fifo_full = 1'b0;
      ticks(1);
      check_eq("ovf_set", 64'(bus.overflow_err), 64'd1);
      ticks(10);
      check_eq("ovf_sticky", 64'(bus.overflow_err), 64'd1);

      // asynchronous reset in the middle of WR_DATA
      base_r = rd_cnt;
      push_words(64'h40, 4);
      wait_cnt("arst_wait", 1, base_r + 1, 40);
      #1;
      rst = 1'b1;
      #1;
      check_eq("arst_wr_fifo_rd", 64'(bus.wr_fifo_rd), 64'd0);
      check_eq("arst_state", 64'(dut.state_r), 64'd0);
      check_eq("arst_level", 64'(bus.ring_level), 64'd0);
      check_eq("arst_empty", 64'(bus.ring_empty), 64'd1);
      check_eq("arst_ovf", 64'(bus.overflow_err), 64'd0);
      check_eq("arst_af_wren", 64'(bus.app_af_wren), 64'd0);
      ticks(2);
      rst = 1'b0;
      ticks(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
